// File: rtl/key_rate_ctrl.sv
// Push-button rate control: synchronises and debounces the active-low KEYs, then
// drives a saturating rate value with press/hold auto-repeat and a change strobe.
module key_rate_ctrl #(
    parameter int RATE_W        = 8,
    parameter int RATE_MIN      = 1,
    parameter int RATE_MAX      = 51,
    parameter int RATE_DEFAULT  = 3,
    parameter int DEB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_W         = 26
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [2:0]        KEY,
    output logic [RATE_W-1:0] rate,
    output logic              rate_chg,
    output logic [2:0]        keys_db,
    output logic              at_min,
    output logic              at_max
);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_HOLD} state_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_RESTORE, ACT_UP, ACT_DOWN} act_t;

    localparam logic [RATE_W-1:0] LP_MIN    = RATE_W'(RATE_MIN);
    localparam logic [RATE_W-1:0] LP_MAX    = RATE_W'(RATE_MAX);
    localparam logic [RATE_W-1:0] LP_DEF    = RATE_W'(RATE_DEFAULT);
    localparam logic [RATE_W-1:0] LP_RONE   = RATE_W'(1);
    localparam logic [CNT_W-1:0]  LP_DEB    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LP_DELAY  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]  LP_PERIOD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0]  LP_CONE   = CNT_W'(1);

    generate
        if (RATE_MIN > RATE_DEFAULT || RATE_DEFAULT > RATE_MAX ||
            REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || DEB_CYCLES < 2) begin : g_param_check
            $error("key_rate_ctrl: illegal parameter combination");
        end
    endgenerate

    logic [2:0]        r_sync1, r_sync2;
    logic [2:0]        w_pressed;
    logic [2:0]        w_keys_db;
    logic              r_restore_prev;
    act_t              w_active, r_active_prev;
    logic              w_act_changed, w_restore_rise;
    state_t            r_state, w_state_next;
    logic [CNT_W-1:0]  r_rep_cnt, w_rep_next;
    logic              r_first, w_first_next;
    logic [RATE_W-1:0] r_rate, w_rate_next;
    logic              r_rate_chg;

    // Released level is 1, so the synchroniser resets to "not pressed".
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            logic [CNT_W-1:0] r_cnt;
            logic             r_db;
            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (w_pressed[gi] != r_db) begin
                    if (r_cnt == LP_DEB) begin
                        r_cnt <= '0;
                        r_db  <= ~r_db;
                    end else begin
                        r_cnt <= r_cnt + LP_CONE;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
            assign w_keys_db[gi] = r_db;
        end
    endgenerate

    always_comb begin
        w_active = ACT_NONE;
        if (w_keys_db[0])      w_active = ACT_RESTORE;
        else if (w_keys_db[1]) w_active = ACT_UP;
        else if (w_keys_db[2]) w_active = ACT_DOWN;
    end

    assign w_act_changed  = (w_active != r_active_prev);
    assign w_restore_rise = w_keys_db[0] & ~r_restore_prev;

    // Rate is registered on the edge entering STEP, so the new value is visible during STEP.
    always_comb begin
        w_state_next = r_state;
        w_rep_next   = r_rep_cnt;
        w_first_next = r_first;
        w_rate_next  = r_rate;
        case (r_state)
            S_IDLE: begin
                if (w_active == ACT_UP || w_active == ACT_DOWN) w_state_next = S_STEP;
            end
            S_STEP: begin
                w_state_next = S_HOLD;
                w_rep_next   = r_first ? LP_DELAY : LP_PERIOD;
                w_first_next = 1'b0;
            end
            S_HOLD: begin
                w_rep_next = r_rep_cnt - LP_CONE;
                if (r_rep_cnt <= LP_CONE) w_state_next = S_STEP;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (r_state != S_IDLE && w_act_changed) w_state_next = S_IDLE;
        if (w_state_next == S_IDLE) w_first_next = 1'b1;
        if (w_restore_rise) begin
            w_rate_next = LP_DEF;
        end else if (w_state_next == S_STEP) begin
            if (w_active == ACT_UP && r_rate < LP_MAX)        w_rate_next = r_rate + LP_RONE;
            else if (w_active == ACT_DOWN && r_rate > LP_MIN) w_rate_next = r_rate - LP_RONE;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state        <= S_IDLE;
            r_rep_cnt      <= '0;
            r_first        <= 1'b1;
            r_rate         <= LP_DEF;
            r_rate_chg     <= 1'b0;
            r_active_prev  <= ACT_NONE;
            r_restore_prev <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_rep_cnt      <= w_rep_next;
            r_first        <= w_first_next;
            r_rate         <= w_rate_next;
            r_rate_chg     <= (w_rate_next != r_rate);
            r_active_prev  <= w_active;
            r_restore_prev <= w_keys_db[0];
        end
    end

    assign rate     = r_rate;
    assign rate_chg = r_rate_chg;
    assign keys_db  = w_keys_db;
    assign at_min   = (r_rate == LP_MIN);
    assign at_max   = (r_rate == LP_MAX);

endmodule

// File: tb/tb_key_rate_ctrl.sv
// Directed bench for key_rate_ctrl: timestamp-based reference model compared every
// cycle, plus hand-computed literal checkpoints along the press/hold scenarios.
module tb_key_rate_ctrl;

    localparam int RW   = 8;
    localparam int RMIN = 1;
    localparam int RMAX = 51;
    localparam int RDEF = 3;
    localparam int DEB  = 4;
    localparam int RDLY = 10;
    localparam int RPER = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    key   = 3'b111;
    logic [RW-1:0] rate;
    logic          rate_chg;
    logic [2:0]    keys_db;
    logic          at_min, at_max;

    key_rate_ctrl #(
        .RATE_W(RW), .RATE_MIN(RMIN), .RATE_MAX(RMAX), .RATE_DEFAULT(RDEF),
        .DEB_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER), .CNT_W(26)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .rate(rate), .rate_chg(rate_chg),
        .keys_db(keys_db), .at_min(at_min), .at_max(at_max)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pcount = 0;
    int mark   = 0;

    always @(posedge clk) pcount <= pcount + 1;

    // Reference model: values visible in the current cycle.
    logic [2:0] m_s1, m_s2, m_db;
    int         m_since [3];
    int         m_rate;
    int         m_chg;
    int         m_prev_act;
    bit         m_busy;
    int         m_next;
    int         m_cyc = 0;

    function automatic int act_of(logic [2:0] db);
        if (db[0]) return 1;
        if (db[1]) return 2;
        if (db[2]) return 3;
        return 0;
    endfunction

    function automatic int apply_step(int r, int a);
        if (a == 2) return (r < RMAX) ? r + 1 : r;
        if (a == 3) return (r > RMIN) ? r - 1 : r;
        return r;
    endfunction

    task automatic model_reset();
        m_s1 = 3'b111; m_s2 = 3'b111; m_db = 3'b000;
        for (int k = 0; k < 3; k++) m_since[k] = -1;
        m_rate = RDEF; m_chg = 0; m_prev_act = 0; m_busy = 1'b0; m_next = -1;
    endtask

    task automatic model_step();
        int a, nr;
        logic [2:0] pr;
        a  = act_of(m_db);
        nr = m_rate;
        if (a == 1 && m_prev_act != 1) nr = RDEF;
        if (m_busy) begin
            if (a != m_prev_act) begin
                m_busy = 1'b0;
                m_next = -1;
            end else if (m_cyc + 1 == m_next) begin
                nr     = apply_step(m_rate, a);
                m_next = m_cyc + 1 + RPER;
            end
        end else if (a == 2 || a == 3) begin
            nr     = apply_step(m_rate, a);
            m_busy = 1'b1;
            m_next = m_cyc + 1 + RDLY;
        end
        m_chg  = (nr != m_rate) ? 1 : 0;
        m_rate = nr;
        pr = ~m_s2;
        for (int k = 0; k < 3; k++) begin
            if (pr[k] != m_db[k]) begin
                if (m_since[k] < 0) m_since[k] = m_cyc;
                if (m_cyc - m_since[k] + 1 == DEB) begin
                    m_db[k]    = ~m_db[k];
                    m_since[k] = -1;
                end
            end else begin
                m_since[k] = -1;
            end
        end
        m_s2 = m_s1;
        m_s1 = key;
        m_prev_act = a;
        m_cyc++;
    endtask

    task automatic cmp(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    initial model_reset();

    always @(posedge clk) if (rst_n) model_step();

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        cmp("rate", int'(rate), m_rate);
        cmp("rate_chg", int'(rate_chg), m_chg);
        cmp("keys_db", int'(keys_db), int'(m_db));
        cmp("at_min", int'(at_min), (m_rate == RMIN) ? 1 : 0);
        cmp("at_max", int'(at_max), (m_rate == RMAX) ? 1 : 0);
    end

    task automatic lit(string name, int dut_v, int mdl_v, int want);
        $display("check %-12s t=%0t dut=%0d model=%0d want=%0d", name, $time, dut_v, mdl_v, want);
        cmp({name, "_dut"}, dut_v, want);
        cmp({name, "_model"}, mdl_v, want);
    endtask

    task automatic lit_dut(string name, int dut_v, int want);
        $display("check %-12s t=%0t dut=%0d want=%0d", name, $time, dut_v, want);
        cmp(name, dut_v, want);
    endtask

    task automatic goto_drive(int k);
        wait (pcount == mark + k);
        #1;
    endtask

    task automatic goto_check(int k);
        wait (pcount == mark + k);
        @(negedge clk);
    endtask

    task automatic set_mark();
        mark = pcount;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        set_mark();

        // Idle and a short glitch on KEY[1]
        goto_check(10);
        lit("idle_rate", int'(rate), m_rate, 3);
        lit("idle_db", int'(keys_db), int'(m_db), 0);
        goto_drive(12); key = 3'b101;
        goto_drive(14); key = 3'b111;
        goto_check(24);
        lit("glitch_db", int'(keys_db), int'(m_db), 0);
        lit("glitch_rate", int'(rate), m_rate, 3);

        // Up held: first step, delayed repeat, periodic repeats, release
        goto_drive(30); key = 3'b101; set_mark();
        goto_check(6);
        lit("up_pre", int'(rate), m_rate, 3);
        lit("up_db", int'(keys_db), int'(m_db), 2);
        goto_check(7);
        lit("up_first", int'(rate), m_rate, 4);
        lit("up_chg", int'(rate_chg), m_chg, 1);
        goto_check(17);
        lit("up_delay", int'(rate), m_rate, 5);
        goto_check(20);
        lit("up_rep1", int'(rate), m_rate, 6);
        goto_check(30);
        lit("up_rep4", int'(rate), m_rate, 9);
        goto_drive(31); key = 3'b111;
        goto_check(60);
        lit("up_release", int'(rate), m_rate, 11);

        // Reset, then down held into RATE_MIN saturation
        goto_drive(62); rst_n = 1'b0;
        @(negedge clk);
        lit_dut("rst_async", int'(rate), 3);
        goto_drive(64); rst_n = 1'b1; key = 3'b011; set_mark();
        goto_check(7);
        lit("dn_first", int'(rate), m_rate, 2);
        goto_check(17);
        lit("dn_min", int'(rate), m_rate, 1);
        lit("dn_at_min", int'(at_min), (m_rate == RMIN) ? 1 : 0, 1);
        goto_check(40);
        lit("dn_sat", int'(rate), m_rate, 1);
        lit("dn_sat_chg", int'(rate_chg), m_chg, 0);

        // Switch to up and climb into RATE_MAX saturation
        goto_drive(41); key = 3'b101;
        goto_check(49);
        lit("mx_first", int'(rate), m_rate, 2);
        goto_check(202);
        lit("mx_50", int'(rate), m_rate, 50);
        goto_check(203);
        lit("mx_51", int'(rate), m_rate, 51);
        lit("mx_at_max", int'(at_max), (m_rate == RMAX) ? 1 : 0, 1);
        goto_check(215);
        lit("mx_sat_chg", int'(rate_chg), m_chg, 0);
        goto_drive(216); key = 3'b111;

        // Up and down together, then release up with down still held
        goto_drive(230); rst_n = 1'b0;
        goto_drive(232); rst_n = 1'b1; key = 3'b001; set_mark();
        goto_check(17);
        lit("both_up", int'(rate), m_rate, 5);
        goto_drive(18); key = 3'b011;
        goto_check(24);
        lit("both_db", int'(keys_db), int'(m_db), 4);
        lit("both_r24", int'(rate), m_rate, 7);
        goto_check(25);
        lit("both_r25", int'(rate), m_rate, 7);
        goto_check(26);
        lit("both_dn", int'(rate), m_rate, 6);
        lit("both_chg", int'(rate_chg), m_chg, 1);
        goto_check(36);
        lit("both_dn2", int'(rate), m_rate, 5);
        goto_drive(37); key = 3'b111;

        // Restore while up repeats, then reset in the middle of a hold
        goto_drive(50); rst_n = 1'b0;
        goto_drive(52); rst_n = 1'b1; key = 3'b101; set_mark();
        goto_drive(62); key = 3'b100;
        @(negedge clk);
        lit("rs_20", int'(rate), m_rate, 20);
        goto_check(68);
        lit("rs_22", int'(rate), m_rate, 22);
        lit("rs_db", int'(keys_db), int'(m_db), 3);
        goto_check(69);
        lit("rs_load", int'(rate), m_rate, 3);
        lit("rs_chg", int'(rate_chg), m_chg, 1);
        goto_check(85);
        lit("rs_hold", int'(rate), m_rate, 3);
        goto_drive(86); key = 3'b101;
        goto_check(93);
        lit("rs_after", int'(rate), m_rate, 4);
        goto_check(106);
        lit("rs_climb", int'(rate), m_rate, 6);
        goto_drive(107); rst_n = 1'b0;
        @(negedge clk);
        lit_dut("rh_rate", int'(rate), 3);
        lit_dut("rh_db", int'(keys_db), 0);
        goto_drive(110); rst_n = 1'b1; set_mark();
        goto_check(6);
        lit("rh_pre", int'(rate), m_rate, 3);
        lit("rh_db2", int'(keys_db), int'(m_db), 2);
        goto_check(7);
        lit("rh_step", int'(rate), m_rate, 4);
        goto_drive(8); key = 3'b111;
        goto_drive(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_rate_ctrl.md
Name: key_rate_ctrl

Overview:
- Front-end for the push-button speed control of the rotating seven-segment blinker.
- Conditions raw active-low KEY inputs with synchronisation and debounce, then runs a press/hold auto-repeat FSM.
- Produces a saturating rate value (counter increment per clock) and a change strobe for the blinker.
- Replaces ad-hoc in-line KEY sampling in display modules.

Parameters:
- RATE_W, 8, width of rate output
- RATE_MIN, 1, lowest rate value
- RATE_MAX, 51, highest rate value
- RATE_DEFAULT, 3, value after reset and on restore key
- DEB_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz)
- REPEAT_DELAY, 25000000, hold cycles from the first step to the first auto-repeat step
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps
- CNT_W, 26, width of internal debounce/repeat counters

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous reset, active-low
- KEY  in  3  raw buttons, active-low: KEY[0] restore default, KEY[1] up, KEY[2] down
- rate  out  RATE_W  current rate value
- rate_chg  out  1  one-cycle pulse in the cycle rate takes a new value
- keys_db  out  3  debounced key state, active-high (1 = pressed)
- at_min  out  1  rate == RATE_MIN (combinational from rate)
- at_max  out  1  rate == RATE_MAX (combinational from rate)

Behaviour:
- Reset (RESET_N low, async): rate=RATE_DEFAULT, rate_chg=0, keys_db=0, sync flops=1 (released), all counters=0, FSM=IDLE. Takes effect immediately, mid-press included. After release, a held key needs full sync plus debounce before it is recognised.
- Sync: each KEY bit passes through a 2-flop synchroniser, then is inverted to pressed-high.
- Debounce, per key:
  - The counter increments while the synced level differs from keys_db, and clears to 0 the cycle it matches.
  - When the counter reaches DEB_CYCLES-1 with the level still differing, keys_db flips next cycle and the counter clears.
  - Glitches shorter than DEB_CYCLES cycles never reach keys_db.
- Priority: restore (KEY[0]) > up > down. The active key is the highest-priority pressed bit of keys_db.
- Restore: on the keys_db[0] rising edge, rate loads RATE_DEFAULT next cycle. Up and down are ignored while keys_db[0]=1.
- FSM states:
  - IDLE: when the active key becomes up or down (at cycle t), go to STEP at t+1.
  - STEP: apply one step; rate and rate_chg update in this cycle. Load repeat counter with REPEAT_DELAY-1, go to HOLD.
  - HOLD: decrement the counter. At 0, go to STEP with next reload REPEAT_PERIOD-1.
  - Any state: if the active key changes (release or higher-priority press), go to IDLE next cycle.
  - A still-held lower-priority key is then treated as a new press. Example: up released while down held gives a down step 2 cycles later.
- Step arithmetic: up sets rate=rate+1 only if rate<RATE_MAX; down sets rate=rate-1 only if rate>RATE_MIN. Saturation, never wrap.
- rate_chg: high exactly in cycles where rate differs from its previous value. A saturated step, or a restore when rate already equals RATE_DEFAULT, produces no pulse.
- Simultaneous up+down: up wins, down ignored until up released.
- Elaboration check: RATE_MIN<=RATE_DEFAULT<=RATE_MAX; REPEAT_DELAY, REPEAT_PERIOD and DEB_CYCLES all >=2.

Test Plan:
(All with DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.)
- Reset, then hold KEY=3'b111 -> rate=3, rate_chg=0, keys_db=0, at_min=0, at_max=0 throughout.
- KEY[1] low for 2 cycles, then high (glitch) -> keys_db[1] stays 0, rate stays 3.
- KEY[1] held low 30 cycles -> keys_db[1] rises after sync+debounce. rate goes 4, then 5 after 10 cycles, then 6, 7, 8, ... every 3 cycles. One rate_chg per step. Release -> stepping stops.
- Rate at 2, KEY[2] held -> rate goes to 1, at_min=1, further repeats produce no rate_chg, rate stays 1. Mirror test from 50 with up -> 51, at_max=1.
- KEY[1] and KEY[2] pressed together at rate 10 -> only increments. Release KEY[1] with KEY[2] still held -> decrement step 2 cycles after keys_db[1] falls.
- Rate 20, up held mid-repeat, press KEY[0] -> rate=3 one cycle after keys_db[0] rises, no further steps while held. Assert RESET_N mid-hold -> rate=3 immediately, no step until full debounce after release.
